mod_share_sched: RTL and testbench

Round-robin scheduler that time-shares a single instance of the 4-bit-in / 1-bit-out `mod` evaluation cell among several requesters. Each requester presents a packed operand slice. The scheduler drives the operand onto the shared cell, waits a fixed number of cycles, and captures the 1-bit result into a per-requester register. It sits in `top`, replacing the per-slice `mod` instances where area matters more than throughput.

---
 rtl/mod_share_sched.sv | 112 +++++++++++
 tb/tb_mod_share_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_share_sched.sv
// Round-robin scheduler that time-shares one 4-bit-in / 1-bit-out evaluation cell
// among NREQ requesters, capturing each result into a per-requester register.
module mod_share_sched #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int LAT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] a_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    y_out,
    output logic [AW-1:0]      mod_a,
    input  logic             mod_y,
    output logic             busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   cur_q, cur_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] y_q, y_d;
    logic [AW-1:0]   moda_q, moda_d;
    logic            busy_q, busy_d;

    logic            sel_vld;
    logic [PW-1:0]   sel_idx;

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_vld && req[(int'(ptr_q) + i) % NREQ]) begin
                sel_vld = 1'b1;
                sel_idx = PW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        y_d     = y_q;
        moda_d  = moda_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    moda_d         = a_in[sel_idx*AW +: AW];
                    gnt_d[sel_idx] = 1'b1;
                    cnt_d          = 3'(LAT);
                    cur_d          = sel_idx;
                    ptr_d          = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Result sampled only here; the operand was frozen at grant.
                    y_d[cur_q]    = mod_y;
                    done_d[cur_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            moda_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            moda_q  <= moda_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign y_out = y_q;
    assign mod_a = moda_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_mod_share_sched.sv
// Bench for mod_share_sched: LAT=0 instance with an XOR-reduce cell model,
// LAT=3 instance with a bench-driven late-settling cell result.
module tb_mod_share_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req0, req1;
    logic [15:0] a0, a1;
    logic [3:0]  gnt0, done0, y0, gnt1, done1, y1;
    logic [3:0]  ma0, ma1;
    logic        my0, my1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign my0 = ^ma0;

    mod_share_sched #(.NREQ(4), .AW(4), .LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .a_in(a0), .gnt(gnt0), .done(done0),
        .y_out(y0), .mod_a(ma0), .mod_y(my0), .busy(busy0));

    mod_share_sched #(.NREQ(4), .AW(4), .LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .a_in(a1), .gnt(gnt1), .done(done1),
        .y_out(y1), .mod_a(ma1), .mod_y(my1), .busy(busy1));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0; req0 = '0; req1 = '0; my1 = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Raise one request on u0, wait for grant and completion.
    task automatic run_one(input int k, input logic [3:0] op);
        bit seen;
        a0[k*4 +: 4] = op;
        req0[k] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (gnt0[k]) begin seen = 1; req0[k] = 1'b0; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL run_one_gnt k=%0d: no grant within budget", k); end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (done0[k]) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL run_one_done k=%0d: no done within budget", k); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req0 = '0; req1 = '0; a0 = '0; a1 = '0; my1 = 1'b0;
        step(); step();
        n_checks++;
        if ({gnt0, done0, y0, ma0, busy0} !== 17'd0) begin
            n_fail++; $display("FAIL reset_u0: got %h want 0", {gnt0, done0, y0, ma0, busy0});
        end
        n_checks++;
        if ({gnt1, done1, y1, ma1, busy1} !== 17'd0) begin
            n_fail++; $display("FAIL reset_u1: got %h want 0", {gnt1, done1, y1, ma1, busy1});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single;
        a0 = 16'h0b00; req0 = 4'b0100;
        step();
        req0 = '0;
        n_checks++;
        if (gnt0 !== 4'b0100 || ma0 !== 4'b1011 || busy0 !== 1'b1) begin
            n_fail++; $display("FAIL single_gnt: gnt=%b mod_a=%b busy=%b want 0100 1011 1", gnt0, ma0, busy0);
        end
        step();
        n_checks++;
        if (done0 !== 4'b0100 || y0 !== 4'b0100 || gnt0 !== 4'b0000 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL single_done: done=%b y=%b gnt=%b busy=%b want 0100 0100 0000 0", done0, y0, gnt0, busy0);
        end
    endtask

    task automatic test_all;
        int order[4]; int tim[4]; int ng;
        logic [3:0] exp_ma;
        do_reset();
        a0 = 16'h8421; req0 = 4'b1111; ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            step();
            for (int k = 0; k < 4; k++) if (gnt0[k]) begin
                order[ng] = k; tim[ng] = c; ng++;
                req0[k] = 1'b0;
                exp_ma = 4'(1 << k);
                n_checks++;
                if (ma0 !== exp_ma) begin n_fail++; $display("FAIL all_moda: got %h want %h", ma0, exp_ma); end
            end
        end
        step();
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL all_count: got %0d grants want 4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != i || (i > 0 && tim[i] - tim[i-1] != 2)) begin
                    n_fail++; $display("FAIL all_order[%0d]: got k=%0d gap=%0d want k=%0d gap=2", i, order[i], (i > 0) ? tim[i] - tim[i-1] : 2, i);
                end
            end
        end
        n_checks++;
        if (y0 !== 4'b1111) begin n_fail++; $display("FAIL all_y: got %b want 1111", y0); end
    endtask

    task automatic test_fairness;
        int seq[4]; int ng; int exp_seq[4];
        exp_seq = '{0, 3, 0, 0};
        a0 = 16'h8001; req0 = 4'b1001; ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            step();
            for (int k = 0; k < 4; k++) if (gnt0[k]) begin
                seq[ng] = k; ng++;
                if (k == 3) req0[3] = 1'b0;
            end
        end
        req0 = '0;
        step(); step();
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL fair_count: got %0d grants want 4", ng);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (seq[i] != exp_seq[i]) begin
                    n_fail++; $display("FAIL fair_seq[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_latency;
        logic [3:0] ops[2];
        logic good;
        int busy_cnt, done_at;
        ops = '{4'b0111, 4'b0011};
        for (int t = 0; t < 2; t++) begin
            good = ^ops[t];
            my1 = ~good;
            a1[7:4] = ops[t]; req1 = 4'b0010;
            step();
            req1 = '0;
            n_checks++;
            if (gnt1 !== 4'b0010 || ma1 !== ops[t]) begin
                n_fail++; $display("FAIL lat_gnt: gnt=%b mod_a=%b want 0010 %b", gnt1, ma1, ops[t]);
            end
            a1[7:4] = ~ops[t];
            busy_cnt = int'(busy1); done_at = -1;
            for (int c = 1; c <= 8; c++) begin
                step();
                if (c == 2) my1 = good;
                busy_cnt += int'(busy1);
                if (done1 != 0 && done_at < 0) begin
                    done_at = c;
                    n_checks++;
                    if (done1 !== 4'b0010) begin n_fail++; $display("FAIL lat_done_bit: got %b want 0010", done1); end
                end
            end
            n_checks++;
            if (done_at != 4) begin n_fail++; $display("FAIL lat_done_time: got %0d want 4", done_at); end
            n_checks++;
            if (busy_cnt != 4) begin n_fail++; $display("FAIL lat_busy: got %0d cycles want 4", busy_cnt); end
            n_checks++;
            if (y1[1] !== good) begin n_fail++; $display("FAIL lat_y: got %b want %b", y1[1], good); end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        do_reset();
        run_one(1, 4'b0001);
        run_one(2, 4'b0111);
        n_checks++;
        if (y0 !== 4'b0110) begin n_fail++; $display("FAIL mid_pre_y: got %b want 0110", y0); end
        a0[15:12] = 4'b0001; req0 = 4'b1000;
        step();
        req0 = '0;
        n_checks++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy0); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt0, done0, y0, ma0, busy0} !== 17'd0) begin
            n_fail++; $display("FAIL mid_async: got %h want 0", {gnt0, done0, y0, ma0, busy0});
        end
        seen = 0;
        step(); if (done0 != 0) seen = 1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin step(); if (done0 != 0) seen = 1; end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL mid_no_done: got done after reset want none"); end
        a0[3:0] = 4'b0001; a0[7:4] = 4'b0011; req0 = 4'b0011;
        step();
        req0[0] = 1'b0;
        n_checks++;
        if (gnt0 !== 4'b0001) begin n_fail++; $display("FAIL mid_first_gnt: got %b want 0001", gnt0); end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin step(); if (gnt0[1]) begin seen = 1; req0[1] = 1'b0; end end
        step(); step();
        n_checks++;
        if (!seen || y0 !== 4'b0001) begin n_fail++; $display("FAIL mid_second: seen=%0d y=%b want 1 0001", seen, y0); end
    endtask

    task automatic test_idle;
        logic [3:0] ma_s, y_s;
        bit bad;
        ma_s = ma0; y_s = y0; bad = 0;
        a0 = 16'hffff;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gnt0 != 0 || done0 != 0 || busy0 != 0 || ma0 !== ma_s || y0 !== y_s) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL idle_hold: mod_a=%b y=%b want %b %b and no activity", ma0, y0, ma_s, y_s); end
        req0 = 4'b1111;
        step();
        req0 = '0;
        n_checks++;
        if (gnt0 !== 4'b0100) begin n_fail++; $display("FAIL idle_ptr: got %b want 0100", gnt0); end
        step(); step();
    endtask

    task automatic test_random;
        int m_ptr, m_cd, m_cur, k;
        logic [3:0] m_y, m_ma, exp_gnt, exp_done, req_s;
        logic [15:0] a_s;
        do_reset();
        m_ptr = 0; m_cd = -1; m_cur = 0; m_y = '0; m_ma = '0;
        a0 = 16'($urandom);
        for (int c = 0; c < 400; c++) begin
            req_s = req0; a_s = a0;
            exp_gnt = '0; exp_done = '0;
            if (m_cd < 0) begin
                if (req_s != 0) begin
                    k = pick(req_s, m_ptr);
                    exp_gnt[k] = 1'b1; m_ma = a_s[k*4 +: 4]; m_cur = k;
                    m_ptr = (k + 1) % 4; m_cd = 1;
                end
            end else begin
                m_cd--;
                if (m_cd == 0) begin
                    exp_done[m_cur] = 1'b1; m_y[m_cur] = ^m_ma; m_cd = -1;
                end
            end
            step();
            n_checks++;
            if (gnt0 !== exp_gnt || done0 !== exp_done || y0 !== m_y || ma0 !== m_ma) begin
                n_fail++;
                $display("FAIL rand c=%0d: gnt/done/y/mod_a=%b %b %b %b want %b %b %b %b",
                         c, gnt0, done0, y0, ma0, exp_gnt, exp_done, m_y, m_ma);
            end
            for (int j = 0; j < 4; j++) begin
                if (gnt0[j]) begin
                    req0[j] = 1'b0; a0[j*4 +: 4] = 4'($urandom);
                end else if (!req0[j]) begin
                    a0[j*4 +: 4] = 4'($urandom);
                    if ($urandom_range(0, 3) == 0) req0[j] = 1'b1;
                end
            end
        end
        req0 = '0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_fairness();
        test_latency();
        test_reset_mid();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
